// File: rtl/alu_responder.sv
// Request/response ALU: 4-bit signed ops, results queued in a 2-entry FIFO.
// Optional statistics counters are built when ALU_RESPONDER_STATS_EN is defined.
module alu_responder (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [1:0] req_tag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_overflow,
  output logic [1:0] rsp_tag
`ifdef ALU_RESPONDER_STATS_EN
  ,
  output logic [7:0] stat_ops,
  output logic [7:0] stat_ovf
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_ILL  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } op_e;

  logic [3:0] sum, diff;
  logic       ovf_add, ovf_sub;
  logic [3:0] alu_res;
  logic       alu_ovf;
  logic       alu_zero;

  assign sum     = req_a + req_b;
  assign diff    = req_a - req_b;
  assign ovf_add = (req_a[3] == req_b[3]) && (sum[3] != req_a[3]);
  assign ovf_sub = (req_a[3] != req_b[3]) && (diff[3] != req_a[3]);

  always_comb begin
    alu_res = 4'b0000;
    alu_ovf = 1'b0;
    case (op_e'(req_op))
      OP_AND:  alu_res = req_a & req_b;
      OP_OR:   alu_res = req_a | req_b;
      OP_ADD:  begin alu_res = sum;  alu_ovf = ovf_add; end
      OP_NAND: alu_res = ~(req_a & req_b);
      OP_NOR:  alu_res = ~(req_a | req_b);
      OP_SUB:  begin alu_res = diff; alu_ovf = ovf_sub; end
      // signed less-than survives wraparound by correcting the sign with the overflow bit
      OP_SLT:  begin alu_res = {3'b000, diff[3] ^ ovf_sub}; alu_ovf = ovf_sub; end
      default: begin alu_res = 4'b0000; alu_ovf = 1'b0; end
    endcase
  end

  assign alu_zero = (alu_res == 4'b0000);

  // entry layout: {result[3:0], zero, overflow, tag[1:0]}
  logic [7:0] mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       push, pop;
  logic [7:0] head;

  assign req_ready = ~count[1];
  assign rsp_valid = (count != 2'd0);
  assign push      = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {alu_res, alu_zero, alu_ovf, req_tag};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // outputs read as zero whenever nothing is buffered, including during reset
  assign rsp_result   = rsp_valid ? head[7:4] : 4'b0000;
  assign rsp_zero     = rsp_valid ? head[3]   : 1'b0;
  assign rsp_overflow = rsp_valid ? head[2]   : 1'b0;
  assign rsp_tag      = rsp_valid ? head[1:0] : 2'b00;

`ifdef ALU_RESPONDER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ops <= 8'd0;
      stat_ovf <= 8'd0;
    end else begin
      if (push && (stat_ops != 8'hFF)) stat_ops <= stat_ops + 8'd1;
      if (push && alu_ovf && (stat_ovf != 8'hFF)) stat_ovf <= stat_ovf + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_responder.sv
// Directed bench for alu_responder with an expected-response queue checked at the consumer side.
module tb_alu_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [1:0] req_tag;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_overflow;
  logic [1:0] rsp_tag;
`ifdef ALU_RESPONDER_STATS_EN
  logic [7:0] stat_ops;
  logic [7:0] stat_ovf;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] sb [$];

  alu_responder dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_tag      (rsp_tag)
`ifdef ALU_RESPONDER_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_ovf     (stat_ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected {result, zero, overflow, tag} from integer arithmetic
  function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [1:0] tag);
    int sa, sbv, t;
    logic [3:0] r;
    logic o;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    t = 0;
    r = 4'b0000;
    o = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin t = sa + sbv; r = t[3:0]; o = (t < -8) || (t > 7); end
      3'b011: r = ~(a & b);
      3'b100: r = ~(a | b);
      3'b110: begin t = sa - sbv; r = t[3:0]; o = (t < -8) || (t > 7); end
      3'b111: begin t = sa - sbv; r = (sa < sbv) ? 4'd1 : 4'd0; o = (t < -8) || (t > 7); end
      default: begin r = 4'b0000; o = 1'b0; end
    endcase
    return {r, (r == 4'b0000), o, tag};
  endfunction

  // consumer side: the visible head must match the oldest expected entry
  always @(negedge clk) begin
    if (reset === 1'b0 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("stale_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        check("rsp_head", {24'd0, rsp_result, rsp_zero, rsp_overflow, rsp_tag}, {24'd0, sb[0]});
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] tag);
    int n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    sb.push_back(model(op, a, b, tag));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
    check("drain_no_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  logic [3:0] bnd_a [8] = '{4'h8, 4'h8, 4'h7, 4'h8, 4'h0, 4'hF, 4'h7, 4'h5};
  logic [3:0] bnd_b [8] = '{4'h8, 4'h1, 4'h8, 4'h7, 4'h0, 4'hF, 4'h7, 4'h3};
  logic [2:0] bnd_o [8] = '{3'b010, 3'b110, 3'b110, 3'b111, 3'b100, 3'b011, 3'b111, 3'b101};

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'b000; req_a = 4'h0; req_b = 4'h0;
    req_tag = 2'b00; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  {31'd0, rsp_valid},    32'd0);
    check("rst_result", {28'd0, rsp_result},   32'd0);
    check("rst_zero",   {31'd0, rsp_zero},     32'd0);
    check("rst_ovf",    {31'd0, rsp_overflow}, 32'd0);
    check("rst_tag",    {30'd0, rsp_tag},      32'd0);
    reset = 1'b0;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // ADD overflow with latency-1 response
    rsp_ready = 1'b1;
    send(3'b010, 4'b0111, 4'b0001, 2'b01);
    check("add_valid",  {31'd0, rsp_valid},    32'd1);
    check("add_result", {28'd0, rsp_result},   32'h8);
    check("add_zero",   {31'd0, rsp_zero},     32'd0);
    check("add_ovf",    {31'd0, rsp_overflow}, 32'd1);
    check("add_tag",    {30'd0, rsp_tag},      32'd1);

    send(3'b110, 4'b1110, 4'b0111, 2'b10);
    check("sub_result", {28'd0, rsp_result},   32'h7);
    check("sub_ovf",    {31'd0, rsp_overflow}, 32'd1);
    send(3'b111, 4'b1101, 4'b0110, 2'b11);
    check("slt_result", {28'd0, rsp_result},   32'h1);
    check("slt_ovf",    {31'd0, rsp_overflow}, 32'd1);
    drain();

    // boundary operands, then a streaming run at occupancy 1
    for (int i = 0; i < 8; i++) send(bnd_o[i], bnd_a[i], bnd_b[i], 2'(i));
    drain();
    for (int i = 0; i < 24; i++) begin
      send(3'(i % 8), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'(i));
      check("stream_valid", {31'd0, rsp_valid}, 32'd1);
      check("stream_ready", {31'd0, req_ready}, 32'd1);
    end
    drain();

    // backpressure: fill, hold a third request, then release
    rsp_ready = 1'b0;
    send(3'b000, 4'h3, 4'h5, 2'b00);
    send(3'b001, 4'h3, 4'h5, 2'b01);
    check("full_ready", {31'd0, req_ready}, 32'd0);
    check("full_valid", {31'd0, rsp_valid}, 32'd1);
    req_valid = 1'b1; req_op = 3'b010; req_a = 4'h2; req_b = 4'h3; req_tag = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    check("held_ready", {31'd0, req_ready}, 32'd0);
    check("held_tag",   {30'd0, rsp_tag},   32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_rises", {31'd0, req_ready}, 32'd1);
    send(3'b010, 4'h2, 4'h3, 2'b10);
    drain();

    // reset with two responses buffered
    rsp_ready = 1'b0;
    send(3'b010, 4'h1, 4'h1, 2'b01);
    send(3'b010, 4'h2, 4'h2, 2'b10);
    reset = 1'b1;
    sb.delete();
    #1;
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_tag",   {30'd0, rsp_tag},   32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_stale", {31'd0, rsp_valid}, 32'd0);
    send(3'b001, 4'h4, 4'h1, 2'b11);
    drain();

`ifdef ALU_RESPONDER_STATS_EN
    reset = 1'b1;
    #1;
    reset = 1'b0;
    check("stat_ops_rst", {24'd0, stat_ops}, 32'd0);
    check("stat_ovf_rst", {24'd0, stat_ovf}, 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) send(3'b010, 4'b0111, 4'b0001, 2'(i));
    drain();
    check("stat_ops_sat", {24'd0, stat_ops}, 32'd255);
    check("stat_ovf_sat", {24'd0, stat_ovf}, 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
